gray_ptr_sync: RTL and testbench

- Consumer stage for Gray-coded values produced by the binary-to-Gray converter, e.g. its g3..g0 outputs carried into another clock domain.
- Synchronises the asynchronous Gray input into clk, converts it back to binary, and classifies every change:
  - a legal single step, with direction, or
  - an illegal multi-bit jump, counted in a saturating error counter.
- Used as the read side of Gray-coded pointers and position encoders.

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_ptr_sync_sync_ff.sv | 30 +++
 rtl/gray_ptr_sync.sv | 116 +++++++++++
 tb/tb_gray_ptr_sync.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the Gray pointer synchroniser.
// Helpers operate on GRAY_MAX_W-bit words; callers zero-extend narrower values.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        FLUSH,
        PRIME,
        RUN,
        HOLD
    } state_t;

    // Each binary bit is the XOR of all Gray bits at or above it, so build it MSB-first.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic onehot_diff(input logic [GRAY_MAX_W-1:0] a,
                                         input logic [GRAY_MAX_W-1:0] b);
        logic [GRAY_MAX_W-1:0] x;
        x = a ^ b;
        return (x != '0) && ((x & (x - GRAY_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_ptr_sync_sync_ff.sv
// Multi-stage flop chain bringing an asynchronous bus into the clk domain.
// Every bit goes through SYNC_STAGES flops; synchronous reset clears the whole chain.
module sync_ff #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Read side of a Gray-coded pointer: synchronises, decodes to binary and classifies
// each change as a directed single step or an illegal multi-bit jump (counted).
module gray_ptr_sync
    import gray_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 en,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step,
    output logic                 dir,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    state_t             state;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [WIDTH-1:0]   g_s;
    logic [WIDTH-1:0]   g_prev;
    logic [WIDTH-1:0]   g_s_bin;
    logic [WIDTH-1:0]   bin_delta;
    logic               is_step;
    logic               is_jump;
    logic               err_event;

    sync_ff #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (g_s)
    );

    always_comb begin
        g_s_bin   = WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));
        bin_delta = g_s_bin - bin_out;
        is_step   = onehot_diff(GRAY_MAX_W'(g_s), GRAY_MAX_W'(g_prev));
        is_jump   = (g_s != g_prev) && !is_step;
        err_event = (state == RUN) && en && is_jump;
    end

    // FLUSH waits out the reset contents of the synchroniser before the first load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            g_prev    <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step      <= 1'b0;
            dir       <= 1'b0;
            err       <= 1'b0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            case (state)
                FLUSH: begin
                    if (flush_cnt == FLUSH_W'(SYNC_STAGES)) begin
                        state <= PRIME;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end
                PRIME: begin
                    g_prev    <= g_s;
                    bin_out   <= g_s_bin;
                    bin_valid <= 1'b1;
                    state     <= en ? RUN : HOLD;
                end
                RUN: begin
                    if (!en) begin
                        state <= HOLD;
                    end else if (is_step) begin
                        step    <= 1'b1;
                        dir     <= (bin_delta == WIDTH'(1));
                        g_prev  <= g_s;
                        bin_out <= g_s_bin;
                    end else if (is_jump) begin
                        err     <= 1'b1;
                        g_prev  <= g_s;
                        bin_out <= g_s_bin;
                    end
                end
                HOLD: begin
                    if (en) begin
                        state <= PRIME;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

    // A clear in the same cycle as an error leaves that error counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= err_event ? ERR_CNT_W'(1) : '0;
        end else if (err_event && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the pointer reader.
module tb_gray_ptr_sync;

    localparam int W       = 4;
    localparam int S       = 2;
    localparam int E       = 8;
    localparam int MASK    = (1 << W) - 1;
    localparam int ERR_MAX = (1 << E) - 1;
    localparam int VW      = W + E + 4;

    localparam int MD_FLUSH = 0;
    localparam int MD_PRIME = 1;
    localparam int MD_RUN   = 2;
    localparam int MD_HOLD  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         clr_err;
    logic [W-1:0] gray_in;
    logic [W-1:0] bin_out;
    logic         bin_valid;
    logic         step;
    logic         dir;
    logic         err;
    logic [E-1:0] err_cnt;

    logic [VW-1:0] obs_vec;
    logic [VW-1:0] exp_vec;

    int tests_run    = 0;
    int tests_failed = 0;

    int q_sync[$];
    int m_mode, m_flush, m_gprev, m_bin, m_valid, m_step, m_dir, m_err, m_errcnt;

    gray_ptr_sync #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .ERR_CNT_W   (E)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .en        (en),
        .clr_err   (clr_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .step      (step),
        .dir       (dir),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    assign obs_vec = {bin_out, bin_valid, step, dir, err, err_cnt};

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b ^= (g >> s);
        return b & MASK;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    task automatic model_reset();
        q_sync = {};
        for (int i = 0; i < S; i++) q_sync.push_back(0);
        m_mode = MD_FLUSH; m_flush = 0; m_gprev = 0; m_bin = 0; m_valid = 0;
        m_step = 0; m_dir = 0; m_err = 0; m_errcnt = 0;
    endtask

    // Abstract view: the value seen by the compare logic is the input from S edges ago.
    task automatic model_edge();
        int gs, d, ev;
        ev = 0;
        if (rst) begin
            model_reset();
        end else begin
            gs = q_sync[$];
            void'(q_sync.pop_back());
            q_sync.push_front(int'(gray_in));
            m_step = 0;
            m_err  = 0;
            case (m_mode)
                MD_FLUSH: if (m_flush == S) m_mode = MD_PRIME; else m_flush++;
                MD_PRIME: begin
                    m_gprev = gs; m_bin = g2b(gs); m_valid = 1;
                    m_mode  = en ? MD_RUN : MD_HOLD;
                end
                MD_RUN: begin
                    if (!en) begin
                        m_mode = MD_HOLD;
                    end else begin
                        d = $countones(gs ^ m_gprev);
                        if (d == 1) begin
                            m_step = 1;
                            m_dir  = (((g2b(gs) - m_bin) & MASK) == 1) ? 1 : 0;
                        end else if (d > 1) begin
                            m_err = 1;
                            ev    = 1;
                        end
                        m_gprev = gs;
                        m_bin   = g2b(gs);
                    end
                end
                default: if (en) m_mode = MD_PRIME;
            endcase
            if (clr_err) m_errcnt = ev;
            else if (ev != 0 && m_errcnt < ERR_MAX) m_errcnt++;
        end
        exp_vec = {W'(m_bin), 1'(m_valid), 1'(m_step), 1'(m_dir), 1'(m_err), E'(m_errcnt)};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic applyStimulus(input int g, input int cycles);
        gray_in = W'(g);
        repeat (cycles) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr_err = 1'b0; gray_in = '0;
        repeat (3) tick();
        tests_run++;
        if (obs_vec !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got %h expected 0", obs_vec);
        end
        rst = 1'b0;
        for (int e = 0; e <= 3; e++) begin
            tick();
            tests_run++;
            if (bin_valid !== (e == 3) || obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL reset_valid edge %0d: got %h expected %h valid=%0d", e, obs_vec, exp_vec, e == 3);
            end
        end
        tests_run++;
        if (bin_out !== 0 || err_cnt !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got bin=%0d cnt=%0d expected 0 0", bin_out, err_cnt);
        end
    endtask

    task automatic test_up_count();
        int steps = 0, errs = 0;
        for (int i = 1; i <= 16; i++) begin
            gray_in = W'(b2g(i % 16));
            for (int c = 1; c <= 4; c++) begin
                tick();
                tests_run++;
                if (obs_vec !== exp_vec) begin
                    tests_failed++;
                    $display("[TB] FAIL up_model i=%0d c=%0d: got %h expected %h", i, c, obs_vec, exp_vec);
                end
                if (step) steps++;
                if (err) errs++;
                if (c == 2) begin
                    tests_run++;
                    if (step !== 1'b0 || bin_out !== W'((i - 1) % 16)) begin
                        tests_failed++;
                        $display("[TB] FAIL up_early i=%0d: got bin=%0d step=%0d expected %0d 0", i, bin_out, step, (i - 1) % 16);
                    end
                end
                if (c == 3) begin
                    tests_run++;
                    if (step !== 1'b1 || dir !== 1'b1 || bin_out !== W'(i % 16)) begin
                        tests_failed++;
                        $display("[TB] FAIL up_step i=%0d: got bin=%0d step=%0d dir=%0d expected %0d 1 1", i, bin_out, step, dir, i % 16);
                    end
                end
            end
        end
        tests_run++;
        if (steps != 16 || errs != 0) begin
            tests_failed++;
            $display("[TB] FAIL up_totals: got steps=%0d errs=%0d expected 16 0", steps, errs);
        end
    endtask

    // Rows: gray value, expected binary, expected step(1)/err(0), expected dir.
    task automatic test_down_and_jump();
        int tbl[8][4] = '{
            '{4'b0001, 1, 1, 1}, '{4'b0011, 2, 1, 1}, '{4'b0001, 1, 1, 0},
            '{4'b0000, 0, 1, 0}, '{4'b1000, 15, 1, 0}, '{4'b0000, 0, 1, 1},
            '{4'b0011, 2, 0, 0}, '{4'b0010, 3, 1, 1}};
        for (int r = 0; r < 8; r++) begin
            applyStimulus(tbl[r][0], 3);
            tests_run++;
            if (step !== 1'(tbl[r][2]) || err !== 1'(!tbl[r][2]) || bin_out !== W'(tbl[r][1])
                || (tbl[r][2] == 1 && dir !== 1'(tbl[r][3])) || obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL step_row %0d: got bin=%0d step=%0d err=%0d dir=%0d expected bin=%0d step=%0d dir=%0d",
                         r, bin_out, step, err, dir, tbl[r][1], tbl[r][2], tbl[r][3]);
            end
            if (r == 6) begin
                tests_run++;
                if (err_cnt !== 1) begin
                    tests_failed++;
                    $display("[TB] FAIL jump_count: got %0d expected 1", err_cnt);
                end
            end
            applyStimulus(tbl[r][0], 1);
        end
    endtask

    task automatic test_saturation();
        int cur, v;
        cur = int'(gray_in);
        for (int n = 0; n < 300; n++) begin
            do v = int'($urandom_range(0, MASK)); while ($countones(v ^ cur) < 2);
            cur = v;
            gray_in = W'(v);
            repeat ($urandom_range(1, 3)) begin
                tick();
                tests_run++;
                if (obs_vec !== exp_vec || (step && err)) begin
                    tests_failed++;
                    $display("[TB] FAIL sat_model n=%0d: got %h expected %h", n, obs_vec, exp_vec);
                end
            end
        end
        applyStimulus(cur, 3);
        tests_run++;
        if (err_cnt !== E'(ERR_MAX)) begin
            tests_failed++;
            $display("[TB] FAIL sat_stick: got %0d expected %0d", err_cnt, ERR_MAX);
        end
        do v = int'($urandom_range(0, MASK)); while ($countones(v ^ cur) < 2);
        applyStimulus(v, 2);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests_run++;
        if (err !== 1'b1 || err_cnt !== 1 || obs_vec !== exp_vec) begin
            tests_failed++;
            $display("[TB] FAIL clr_with_err: got err=%0d cnt=%0d expected 1 1", err, err_cnt);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests_run++;
        if (err !== 1'b0 || err_cnt !== 0) begin
            tests_failed++;
            $display("[TB] FAIL clr_alone: got err=%0d cnt=%0d expected 0 0", err, err_cnt);
        end
    endtask

    task automatic test_enable_and_reset();
        int pulses = 0;
        applyStimulus(0, 4);
        en = 1'b0;
        tick();
        for (int r = 0; r < 2; r++) begin
            gray_in = (r == 0) ? 4'b0011 : 4'b0010;
            repeat (4) begin
                tick();
                if (step || err) pulses++;
            end
        end
        tests_run++;
        if (pulses != 0 || bin_out !== 0 || bin_valid !== 1'b1 || obs_vec !== exp_vec) begin
            tests_failed++;
            $display("[TB] FAIL enable_hold: got bin=%0d pulses=%0d valid=%0d expected 0 0 1", bin_out, pulses, bin_valid);
        end
        en = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (bin_out !== 3 || step !== 1'b0 || err !== 1'b0 || obs_vec !== exp_vec) begin
            tests_failed++;
            $display("[TB] FAIL enable_prime: got bin=%0d step=%0d err=%0d expected 3 0 0", bin_out, step, err);
        end
        applyStimulus(4'b0110, 3);
        tests_run++;
        if (bin_out !== 4 || step !== 1'b1 || dir !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL enable_step: got bin=%0d step=%0d dir=%0d expected 4 1 1", bin_out, step, dir);
        end
        applyStimulus(4'b0111, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (obs_vec !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got %h expected 0", obs_vec);
        end
        for (int e = 0; e <= 3; e++) begin
            tick();
            tests_run++;
            if (bin_valid !== (e == 3) || obs_vec !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL reflush edge %0d: got %h expected %h", e, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        int b, sel;
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 8) en = ~en;
            clr_err = ($urandom_range(0, 99) < 4);
            rst     = ($urandom_range(0, 299) == 0);
            b = g2b(int'(gray_in));
            if (sel >= 20 && sel < 45) gray_in = W'(b2g((b + 1) & MASK));
            else if (sel >= 45 && sel < 60) gray_in = W'(b2g((b - 1) & MASK));
            else if (sel >= 60 && sel < 70) gray_in = W'($urandom_range(0, MASK));
            tick();
            tests_run++;
            if (obs_vec !== exp_vec || (step && err)) begin
                tests_failed++;
                $display("[TB] FAIL random n=%0d: got %h expected %h", n, obs_vec, exp_vec);
            end
        end
        rst = 1'b0; clr_err = 1'b0; en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr_err = 1'b0; gray_in = '0;
        model_reset();
        exp_vec = '0;
        test_reset();
        test_up_count();
        test_down_and_jump();
        test_saturation();
        test_enable_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
